// File: rtl/axi_llc_pkg.sv
// Shared LLC types: static cache configuration and the partition-table FSM states.
package axi_llc_pkg;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned BlockSize;
    int unsigned TagLength;
    int unsigned IndexLength;
    int unsigned BlockOffsetLength;
    int unsigned ByteOffsetLength;
    int unsigned SPMLength;
  } llc_cfg_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    CHECK  = 3'd2,
    FLUSH  = 3'd3,
    COMMIT = 3'd4
  } part_cfg_state_e;

  // Counter/ID width that stays legal for single-entry tables.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/axi_llc_partition_ctrl.sv
// Cache-partition table: SW fills a shadow table, a commit packs it from index 0,
// validates it, flushes the LLC and then swaps it atomically into the active table.
module axi_llc_partition_ctrl
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t    Cfg              = llc_cfg_t'{default: '0},
  parameter int unsigned NumPartitions    = 32'd4,
  parameter type         partition_size_t = logic [$clog2(Cfg.NumLines):0],
  parameter type         index_t          = logic [((Cfg.IndexLength > 32'd0) ? Cfg.IndexLength : 32'd1)-1:0],
  localparam int unsigned IdW             = clog2_min1(NumPartitions)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [IdW-1:0]  cfg_id_i,
  input  partition_size_t cfg_size_i,
  input  logic            commit_valid_i,
  output logic            commit_ready_o,
  output logic            busy_o,
  output logic            cfg_err_o,
  output logic            flush_req_o,
  input  logic            flush_ack_i,
  input  logic [IdW-1:0]  lkp_id_i,
  output partition_size_t lkp_pat_size_o,
  output index_t          lkp_start_index_o,
  output partition_size_t share_size_o,
  output index_t          share_index_o
);

  localparam int unsigned LineW = (Cfg.NumLines > 32'd1) ? $clog2(Cfg.NumLines) : 32'd1;
  // Wide enough for NumPartitions full-cache sizes, so an over-subscription never wraps.
  localparam int unsigned AccW  = LineW + 32'd1 + IdW;

  typedef logic [AccW-1:0] acc_t;
  typedef logic [IdW-1:0]  idx_t;

  typedef struct packed {
    partition_size_t pat_size;
    index_t          start_index;
  } part_cfg_t;

  localparam acc_t            NumLinesAcc  = acc_t'(Cfg.NumLines);
  localparam partition_size_t NumLinesSize = partition_size_t'(Cfg.NumLines);

  part_cfg_state_e state_r;
  idx_t            idx_r;
  acc_t            acc_r;
  logic            any_zero_r;
  logic            busy_r;
  logic            cfg_err_r;
  logic            flush_req_r;
  partition_size_t share_size_nxt_r;
  index_t          share_index_nxt_r;

  part_cfg_t       shadow_r [NumPartitions];
  part_cfg_t       active_r [NumPartitions];
  partition_size_t share_size_r;
  index_t          share_index_r;

  logic            cfg_fire_s;
  logic            cfg_id_ok_s;

  // A fully packed table with an empty partition would leave that partition no lines at all.
  function automatic logic reject_commit(input acc_t acc, input logic any_zero);
    return (acc > NumLinesAcc) || ((acc == NumLinesAcc) && any_zero);
  endfunction

  assign cfg_fire_s  = cfg_valid_i && !busy_r;
  assign cfg_id_ok_s = (32'(cfg_id_i) < NumPartitions);

  // Shadow table: SW size writes in IDLE, packed start indices during CALC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumPartitions); i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      if (cfg_fire_s && cfg_id_ok_s) begin
        shadow_r[cfg_id_i].pat_size <= cfg_size_i;
      end
      if (state_r == CALC) begin
        shadow_r[idx_r].start_index <= index_t'(acc_r);
      end
    end
  end

  // Commit sequencer: pack, validate, flush handshake, apply.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r           <= IDLE;
      idx_r             <= '0;
      acc_r             <= '0;
      any_zero_r        <= 1'b0;
      busy_r            <= 1'b0;
      cfg_err_r         <= 1'b0;
      flush_req_r       <= 1'b0;
      share_size_nxt_r  <= NumLinesSize;
      share_index_nxt_r <= '0;
    end else begin
      cfg_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (commit_valid_i) begin
            state_r    <= CALC;
            busy_r     <= 1'b1;
            idx_r      <= '0;
            acc_r      <= '0;
            any_zero_r <= 1'b0;
          end
        end
        CALC: begin
          acc_r <= acc_r + acc_t'(shadow_r[idx_r].pat_size);
          if (shadow_r[idx_r].pat_size == '0) begin
            any_zero_r <= 1'b1;
          end
          if (32'(idx_r) == NumPartitions - 32'd1) begin
            state_r <= CHECK;
          end else begin
            idx_r <= idx_r + idx_t'(1);
          end
        end
        CHECK: begin
          if (reject_commit(acc_r, any_zero_r)) begin
            cfg_err_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else begin
            share_size_nxt_r  <= partition_size_t'(NumLinesAcc - acc_r);
            share_index_nxt_r <= index_t'(acc_r);
            flush_req_r       <= 1'b1;
            state_r           <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_ack_i && flush_req_r) begin
            flush_req_r <= 1'b0;
            state_r     <= COMMIT;
          end
        end
        COMMIT: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r      <= 1'b0;
          flush_req_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Active table: only ever loaded as a whole, so lookups never see a half-applied table.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumPartitions); i++) begin
        active_r[i] <= '0;
      end
      share_size_r  <= NumLinesSize;
      share_index_r <= '0;
    end else if (state_r == COMMIT) begin
      for (int i = 0; i < int'(NumPartitions); i++) begin
        active_r[i] <= shadow_r[i];
      end
      share_size_r  <= share_size_nxt_r;
      share_index_r <= share_index_nxt_r;
    end
  end

  // Zero-latency lookup from the active table.
  always_comb begin
    lkp_pat_size_o    = '0;
    lkp_start_index_o = '0;
    if (32'(lkp_id_i) < NumPartitions) begin
      lkp_pat_size_o    = active_r[lkp_id_i].pat_size;
      lkp_start_index_o = active_r[lkp_id_i].start_index;
    end else begin
      lkp_pat_size_o    = '0;
      lkp_start_index_o = '0;
    end
  end

  assign cfg_ready_o    = !busy_r;
  assign commit_ready_o = !busy_r;
  assign busy_o         = busy_r;
  assign cfg_err_o      = cfg_err_r;
  assign flush_req_o    = flush_req_r;
  assign share_size_o   = share_size_r;
  assign share_index_o  = share_index_r;

endmodule
